// File: rtl/tap_fsm.sv
// IEEE 1149.1 TAP controller: decodes the TMS stream into the 16 TAP states and
// drives Moore-decoded strobes for the instruction-register and data-register cells.
module tap_fsm (
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output logic [3:0] state_o,
    output logic       ir_rst,
    output logic       ir_shift,
    output logic       ir_clock,
    output logic       ir_upd,
    output logic       dr_shift,
    output logic       dr_clock,
    output logic       dr_upd,
    output logic       sel_ir,
    output logic       tdo_oe
);

    // Standard 1149.1 codes; every 4-bit value is a legal state.
    typedef enum logic [3:0] {
        S_EX2_DR = 4'h0,
        S_EX1_DR = 4'h1,
        S_SH_DR  = 4'h2,
        S_PAU_DR = 4'h3,
        S_SEL_IR = 4'h4,
        S_UPD_DR = 4'h5,
        S_CAP_DR = 4'h6,
        S_SEL_DR = 4'h7,
        S_EX2_IR = 4'h8,
        S_EX1_IR = 4'h9,
        S_SH_IR  = 4'hA,
        S_PAU_IR = 4'hB,
        S_RTI    = 4'hC,
        S_UPD_IR = 4'hD,
        S_CAP_IR = 4'hE,
        S_TLR    = 4'hF
    } tap_state_t;

    tap_state_t r_state;
    tap_state_t w_next;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            r_state <= S_TLR;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
        w_next = r_state;
        case (r_state)
            S_TLR:    w_next = tms ? S_TLR    : S_RTI;
            S_RTI:    w_next = tms ? S_SEL_DR : S_RTI;
            S_SEL_DR: w_next = tms ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: w_next = tms ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  w_next = tms ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: w_next = tms ? S_UPD_DR : S_PAU_DR;
            S_PAU_DR: w_next = tms ? S_EX2_DR : S_PAU_DR;
            S_EX2_DR: w_next = tms ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: w_next = tms ? S_SEL_DR : S_RTI;
            S_SEL_IR: w_next = tms ? S_TLR    : S_CAP_IR;
            S_CAP_IR: w_next = tms ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  w_next = tms ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: w_next = tms ? S_UPD_IR : S_PAU_IR;
            S_PAU_IR: w_next = tms ? S_EX2_IR : S_PAU_IR;
            S_EX2_IR: w_next = tms ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: w_next = tms ? S_SEL_DR : S_RTI;
            default:  w_next = S_TLR;
        endcase
    end

    // Moore output decode: depends only on r_state, never on tms.
    always_comb begin
        ir_rst   = 1'b0;
        ir_shift = 1'b0;
        ir_clock = 1'b0;
        ir_upd   = 1'b0;
        dr_shift = 1'b0;
        dr_clock = 1'b0;
        dr_upd   = 1'b0;
        sel_ir   = 1'b0;
        case (r_state)
            S_TLR:    ir_rst = 1'b1;
            S_CAP_DR: dr_clock = 1'b1;
            S_SH_DR: begin
                dr_clock = 1'b1;
                dr_shift = 1'b1;
            end
            S_UPD_DR: dr_upd = 1'b1;
            S_SEL_IR, S_EX1_IR, S_PAU_IR, S_EX2_IR: sel_ir = 1'b1;
            S_CAP_IR: begin
                sel_ir   = 1'b1;
                ir_clock = 1'b1;
            end
            S_SH_IR: begin
                sel_ir   = 1'b1;
                ir_clock = 1'b1;
                ir_shift = 1'b1;
            end
            S_UPD_IR: begin
                sel_ir = 1'b1;
                ir_upd = 1'b1;
            end
            default: ;
        endcase
    end

    assign tdo_oe  = ir_shift | dr_shift;
    assign state_o = r_state;

endmodule
